// File: rtl/narrow_store.sv
// narrow_store: narrows a 32-bit value to byte, halfword or word and writes it
// through a 16-bit memory port with a valid/ack handshake. Word stores are
// split into two halfword writes, low half first. Reports signed overflow of
// the narrowing and misaligned/illegal requests on a one-cycle done pulse.
module narrow_store #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WR0, WR1, FIN} state_t;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  state_t            state_reg, state_next;
  logic [31:0]       data_reg;
  logic [1:0]        mode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              ovf_reg, err_reg;

  logic              req_err, req_ovf;
  logic              byte_fits, half_fits;

  // Classify the incoming request: the truncated value fits when every bit
  // above the kept sign bit equals that sign bit.
  always_comb begin
    byte_fits = (&data_in[31:7])  | ~(|data_in[31:7]);
    half_fits = (&data_in[31:15]) | ~(|data_in[31:15]);
    req_err   = (mode == MODE_ILL) || ((mode != MODE_BYTE) && addr[0]);
    req_ovf   = 1'b0;
    if (!req_err) begin
      case (mode)
        MODE_BYTE: req_ovf = ~byte_fits;
        MODE_HALF: req_ovf = ~half_fits;
        default:   req_ovf = 1'b0;
      endcase
    end
  end

  // State register plus request capture; status flags only change on an
  // accepted start so they stay readable after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      mode_reg  <= '0;
      addr_reg  <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        data_reg <= data_in;
        mode_reg <= mode;
        addr_reg <= addr;
        ovf_reg  <= req_ovf;
        err_reg  <= req_err;
      end
    end
  end

  // Next-state and memory port decode; the port is idle (all zero) outside
  // the two write states.
  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = 2'b00;
    case (state_reg)
      IDLE: begin
        if (start) state_next = req_err ? FIN : WR0;
      end
      WR0: begin
        mem_we = 1'b1;
        if (mode_reg == MODE_BYTE) begin
          mem_addr = {addr_reg[ADDR_W-1:1], 1'b0};
          if (addr_reg[0]) begin
            mem_be    = 2'b10;
            mem_wdata = {data_reg[7:0], 8'h00};
          end else begin
            mem_be    = 2'b01;
            mem_wdata = {8'h00, data_reg[7:0]};
          end
        end else begin
          mem_addr  = addr_reg;
          mem_be    = 2'b11;
          mem_wdata = data_reg[15:0];
        end
        if (mem_ack) state_next = (mode_reg == MODE_WORD) ? WR1 : FIN;
      end
      WR1: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg + ADDR_W'(2);
        mem_be    = 2'b11;
        mem_wdata = data_reg[31:16];
        if (mem_ack) state_next = FIN;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs derived from state and the held flags.
  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == FIN);
    ovf  = ovf_reg;
    err  = err_reg;
  end

endmodule

// File: tb/tb_narrow_store.sv
// Self-checking bench for narrow_store: expected memory writes are queued when
// a store is issued and popped as the DUT presents each accepted write.
module tb_narrow_store;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, start, mem_ack;
  logic [1:0]    mode, mem_be;
  logic [AW-1:0] addr, mem_addr;
  logic [31:0]   data_in;
  logic [15:0]   mem_wdata;
  logic          mem_we, busy, done, ovf, err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [1:0]    be;
  } wr_t;

  wr_t exp_q[$];

  narrow_store #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .addr(addr),
    .data_in(data_in), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: value fits when it lies in the signed range of the width.
  function automatic logic model_ovf(input logic [1:0] m, input logic [31:0] d);
    int v;
    v = $signed(d);
    case (m)
      2'b00:   return !(v >= -128 && v <= 127);
      2'b01:   return !(v >= -32768 && v <= 32767);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] m, input logic [AW-1:0] a);
    return (m == 2'b11) || (m != 2'b00 && a[0] == 1'b1);
  endfunction

  task automatic push_expected(input logic [1:0] m, input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    logic [AW-1:0] a2;
    if (model_err(m, a)) return;
    if (m == 2'b00) begin
      w.a  = {a[AW-1:1], 1'b0};
      w.d  = a[0] ? {d[7:0], 8'h00} : {8'h00, d[7:0]};
      w.be = a[0] ? 2'b10 : 2'b01;
      exp_q.push_back(w);
    end else begin
      w.a = a; w.d = d[15:0]; w.be = 2'b11;
      exp_q.push_back(w);
      if (m == 2'b10) begin
        a2 = a + 2;
        w.a = a2; w.d = d[31:16]; w.be = 2'b11;
        exp_q.push_back(w);
      end
    end
  endtask

  // Issue one store, answer each write after dly idle cycles, check timing,
  // scoreboard writes, port stability and final status.
  task automatic do_store(input logic [1:0] m, input logic [AW-1:0] a, input logic [31:0] d,
                          input int dly, input bit junk, input string name);
    int  edges, wcnt, exp_edges, nwr;
    bit  seen;
    logic eo, ee;
    wr_t held, cur, w;
    ee = model_err(m, a);
    eo = ee ? 1'b0 : model_ovf(m, d);
    nwr = ee ? 0 : ((m == 2'b10) ? 2 : 1);
    exp_edges = 1 + nwr * (dly + 1);
    push_expected(m, a, d);
    @(negedge clk);
    mode = m; addr = a; data_in = d; start = 1'b1; mem_ack = 1'b0;
    edges = 0; wcnt = 0; seen = 0; held = '0;
    while (!seen && edges < 60) begin
      @(posedge clk); edges++; #1;
      if (junk) begin
        start = 1'b1; mode = 2'($urandom); addr = $urandom; data_in = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1; start = 1'b0; mem_ack = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 16'h0 || mem_be !== 2'b00) begin
          errors++;
          $display("FAIL %s fin_port: we=%b addr=%h wdata=%h be=%b want all 0", name, mem_we, mem_addr, mem_wdata, mem_be);
        end
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy: got %b want 1", name, busy);
        end
        cur = {mem_addr, mem_wdata, mem_be};
        if (mem_we === 1'b1) begin
          if (wcnt == 0) held = cur;
          else begin
            checks++;
            if (cur !== held) begin
              errors++; $display("FAIL %s stable: got %h want %h", name, cur, held);
            end
          end
          if (wcnt == dly) begin
            mem_ack = 1'b1; wcnt = 0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL %s extra_write: got %h want none", name, cur);
            end else begin
              w = exp_q.pop_front();
              if (cur !== w) begin
                errors++;
                $display("FAIL %s write: got addr=%h data=%h be=%b want addr=%h data=%h be=%b",
                         name, mem_addr, mem_wdata, mem_be, w.a, w.d, w.be);
              end
            end
          end else begin
            mem_ack = 1'b0; wcnt++;
          end
        end else begin
          errors++;
          $display("FAIL %s we_drop: busy without write or done, we=%b want 1", name, mem_we);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: no done within %0d edges", name, edges);
    end
    checks++;
    if (edges != exp_edges) begin
      errors++; $display("FAIL %s latency: got %0d edges want %0d", name, edges, exp_edges);
    end
    checks++;
    if (ovf !== eo || err !== ee) begin
      errors++; $display("FAIL %s flags: got ovf=%b err=%b want ovf=%b err=%b", name, ovf, err, eo, ee);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s missing_write: got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ovf !== eo || err !== ee) begin
      errors++;
      $display("FAIL %s after_fin: got done=%b busy=%b ovf=%b err=%b want 0 0 %b %b", name, done, busy, ovf, err, eo, ee);
    end
    $display("store %s mode=%b addr=%h data=%h dly=%0d edges=%0d ovf=%b err=%b", name, m, a, d, dly, edges, ovf, err);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 16'h0 || mem_be !== 2'b00 ||
        busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s zero: got we=%b addr=%h wdata=%h be=%b busy=%b done=%b ovf=%b err=%b want all 0",
               name, mem_we, mem_addr, mem_wdata, mem_be, busy, done, ovf, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mem_ack = 1'b1; mode = 2'b10; addr = 32'h10; data_in = 32'hFFFF_0000;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_word();
    do_store(2'b10, 32'h100, 32'h1234_5678, 0, 0, "word");
    do_store(2'b10, 32'hFFFF_FFFE, 32'hAAAA_5555, 0, 0, "word_wrap");
  endtask

  task automatic test_byte();
    do_store(2'b00, 32'h201, 32'hFFFF_FF91, 0, 0, "byte_hi");
    do_store(2'b00, 32'h204, 32'h0000_007F, 0, 0, "byte_max");
    do_store(2'b00, 32'h205, 32'h0000_0080, 0, 0, "byte_ovf");
    do_store(2'b00, 32'h206, 32'hFFFF_FF80, 0, 0, "byte_min");
  endtask

  task automatic test_half();
    do_store(2'b01, 32'h300, 32'h0000_9111, 0, 0, "half_ovf");
    do_store(2'b01, 32'h300, 32'hFFFF_9111, 0, 0, "half_ok");
    do_store(2'b01, 32'h302, 32'h0000_7FFF, 0, 0, "half_max");
  endtask

  task automatic test_err();
    do_store(2'b01, 32'h003, 32'h0000_9111, 0, 0, "err_half");
    do_store(2'b11, 32'h010, 32'h0000_0001, 0, 0, "err_mode");
    do_store(2'b10, 32'h105, 32'h1234_5678, 0, 0, "err_word");
  endtask

  task automatic test_delayed();
    do_store(2'b10, 32'h400, 32'hDEAD_BEEF, 3, 1, "word_delay");
    do_store(2'b00, 32'h403, 32'h0001_0042, 2, 1, "byte_delay");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mode = 2'b10; addr = 32'h300; data_in = 32'hCAFE_BABE; start = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 16'hBABE) begin
      errors++; $display("FAIL rst_mid wr0: got we=%b addr=%h data=%h want 1 00000300 babe", mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h302 || mem_wdata !== 16'hCAFE) begin
      errors++; $display("FAIL rst_mid wr1: got we=%b addr=%h data=%h want 1 00000302 cafe", mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_all_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid idle%0d: got done=%b we=%b busy=%b want 0 0 0", i, done, mem_we, busy);
      end
    end
    mem_ack = 1'b0;
    $display("reset mid-store aborted");
    do_store(2'b10, 32'h500, 32'h0BAD_F00D, 0, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  m;
    logic [31:0] d, a;
    for (int i = 0; i < 12; i++) begin
      m = 2'($urandom_range(0, 2));
      a = $urandom & 32'hFFFF_FFFE;
      if (m == 2'b00) a[0] = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       d = $urandom;
        1:       d = 32'($signed(8'($urandom)));
        default: d = 32'($signed(16'($urandom)));
      endcase
      do_store(m, a, d, $urandom_range(0, 2), 1'($urandom), "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_err();
    test_delayed();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/narrow_store.md
NARROW_STORE -- requirements
Module: narrow_store

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of the addr and mem_addr ports.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 mode  input  2  store width: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 addr  input  ADDR_W  byte address of the store.
REQ-007 data_in  input  32  value to narrow and store.
REQ-008 mem_we  output  1  write request to the 16-bit memory port.
REQ-009 mem_addr  output  ADDR_W  halfword-aligned address, bit 0 always 0.
REQ-010 mem_wdata  output  16  write data.
REQ-011 mem_be  output  2  byte enables: bit0 = low byte, bit1 = high byte.
REQ-012 mem_ack  input  1  memory accepted the current write.
REQ-013 busy  output  1  high in every state other than IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 ovf  output  1  data_in is not representable as a signed value of the chosen width; valid while done is high.
REQ-016 err  output  1  misaligned or illegal request; valid while done is high.

Function
REQ-017 The block SHALL use the FSM states IDLE, WR0, WR1 and FIN.
REQ-018 IDLE with start=1: latch data_in, mode and addr; compute ovf and err; go to WR0, or to FIN if err=1.
REQ-019 start while busy=1 SHALL be ignored; it is neither queued nor able to alter the latched values.
REQ-020 ovf rule (the inverse of sign extension):
- byte: ovf=1 unless data_in[31:7] is all-equal
- half: ovf=1 unless data_in[31:15] is all-equal
- word: ovf=0
REQ-021 ovf SHALL NOT suppress the store; the truncated low bits are written regardless.
REQ-022 err=1 for mode=11, or for half or word with addr[0]=1; no memory write occurs and ovf=0.
REQ-023 In WR0 and WR1, mem_we SHALL be held at 1 with stable mem_addr, mem_wdata and mem_be until mem_ack=1 is sampled, with no timeout.
REQ-024 Byte store in WR0:
- mem_addr = {addr[ADDR_W-1:1], 0}
- addr[0]=0: mem_be=01, mem_wdata={8'h00, d[7:0]}
- addr[0]=1: mem_be=10, mem_wdata={d[7:0], 8'h00}
- on ack, go to FIN
REQ-025 Half store in WR0: mem_addr=addr, mem_be=11, mem_wdata=d[15:0]; on ack, go to FIN.
REQ-026 Word store, low half first:
- WR0: mem_addr=addr, mem_wdata=d[15:0], mem_be=11; on ack, go to WR1
- WR1: mem_addr=addr+2 (modulo 2^ADDR_W), mem_wdata=d[31:16], mem_be=11; on ack, go to FIN
REQ-027 mem_ack while mem_we=0 SHALL be ignored.
REQ-028 FIN SHALL assert done=1 for exactly one cycle, hold ovf and err, then go to IDLE.
REQ-029 In FIN, mem_we=0 always.
REQ-030 ovf and err SHALL hold their value until the next accepted start.
REQ-031 Latency with mem_ack tied high (start sampled at edge 0):
- byte or half: done high after edge 2
- word: done high after edge 3
- err: done high after edge 1
- the next start is accepted at the edge that leaves FIN+1, i.e. in IDLE
REQ-032 Outside WR0 and WR1: mem_we=0, mem_be=00, mem_wdata=0 and mem_addr=0.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE and make mem_we, mem_be, mem_wdata, mem_addr, busy, done, ovf and err all 0.
REQ-034 rst SHALL take priority over start and mem_ack.
REQ-035 A reset mid-operation SHALL abort the store: no further write, no done pulse, and an outstanding ack is ignored.

Verification
REQ-036 Word 0x12345678, addr 0x100, ack tied high -> write (0x100, 0x5678, be=11), then (0x102, 0x1234); done after 3 edges; ovf=0, err=0.
REQ-037 Byte 0xFFFFFF91, addr 0x201 -> one write (0x200, 0x9100, be=10); ovf=0.
REQ-038 Half 0x00009111 -> write of 0x9111, ovf=1 (does not fit signed 16); a second run with 0xFFFF9111 gives ovf=0.
REQ-039 Half at addr 0x003 -> no mem_we; done one edge after start with err=1. mode=11 gives the same response.
REQ-040 Word store with mem_ack delayed 3 cycles on each half -> mem_we and mem_* stay stable while waiting; start pulses during busy are ignored; done after 9 edges.
REQ-041 rst asserted while in WR1 -> next cycle IDLE with all outputs 0, no done; a fresh start then completes normally.
